lsu_rv32i: RTL and testbench
============================

Name: lsu_rv32i

Overview:
- Load/store unit responding to the memory-op controls the RV32I decoder produces (is_store, mem_size 1/2/4, stall on loads).
- Accepts one access from the execute stage and drives a word-addressed data-memory req/ack port with byte enables.
- Stalls the core until the access completes, then returns sign- or zero-extended load data for register write-back.
- Detects misaligned accesses and memory timeouts.

Parameters:
- TIMEOUT, 16: max cycles o_mem_req is held waiting for i_mem_ack before abort; 0 disables timeout.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset; synchronous, active-high
- i_valid  in  1  core presents a memory op this cycle
- i_is_store  in  1  1 = store, 0 = load
- i_mem_size  in  4  access size in bytes: 1, 2 or 4; any other value is illegal
- i_unsigned  in  1  zero-extend the load (LBU/LHU); this is inst f3[2]
- i_addr  in  32  effective byte address (ALU result)
- i_wdata  in  32  store data (rs2)
- o_busy  out  1  stall the core
- o_rdone  out  1  one-cycle pulse; o_rdata valid, write rd
- o_rdata  out  32  extended load data
- o_misalign  out  1  one-cycle pulse; access rejected
- o_timeout  out  1  one-cycle pulse; memory never acked
- o_mem_req  out  1  memory request
- o_mem_we  out  1  write enable
- o_mem_addr  out  32  word address ({i_addr[31:2],2'b00})
- o_mem_be  out  4  byte enables
- o_mem_wdata  out  32  lane-replicated store data
- i_mem_ack  in  1  request completes this cycle (read data valid)
- i_mem_rdata  in  32  read word

Behaviour:
- States are IDLE, REQ and DONE. On reset: state IDLE, timeout counter 0, all outputs 0.
- Accept occurs when state==IDLE and i_valid=1. On accept, capture is_store, size, unsigned, addr[1:0] and word addr. Capture steered BE/wdata in the same cycle.
- Legality check:
  - size 2 with addr[0]=1 is misaligned.
  - size 4 with addr[1:0]!=0 is misaligned.
  - size not in {1,2,4} is misaligned.
  - A misaligned accept goes directly to DONE with the misalign flag set. No memory request is issued.
- A legal accept goes to REQ.
- REQ:
  - o_mem_req=1 and all mem outputs are stable until ack.
  - On i_mem_ack, latch extracted load data and go to DONE.
  - The counter increments each REQ cycle without ack. If TIMEOUT!=0 and the counter reaches TIMEOUT-1 with no ack, drop req and go to DONE with the timeout flag set.
- DONE (exactly one cycle):
  - o_rdone=1 only for a successful load.
  - o_misalign or o_timeout pulses per the flag; o_rdata is 0 on error.
  - i_valid is ignored. Next state is IDLE.
- o_busy is combinational: (state==IDLE & i_valid) | state==REQ. It is 0 in DONE, and the core advances at the end of DONE. This prevents re-accepting the same instruction.
- Latency for a legal access: with zero-wait memory (ack in first REQ cycle), DONE falls at accept+2 and the core stalls 2 cycles. Each wait cycle adds 1.
- Byte enables:
  - size1: 4'b0001<<addr[1:0]
  - size2: 4'b0011<<addr[1:0]
  - size4: 4'b1111
- Store data: size1 gives {4{wdata[7:0]}}; size2 gives {2{wdata[15:0]}}; size4 gives wdata.
- o_mem_wdata is 0 for loads.
- Load extract: shifted = i_mem_rdata >> (addr[1:0]*8).
  - size1: bit 7 is replicated, or zeros if unsigned.
  - size2: bit 15 is replicated, or zeros if unsigned.
  - size4: the word is used as-is.
- Boundary cases:
  - An ack in IDLE or DONE is ignored.
  - An ack on the same cycle as the timeout limit counts as success; ack wins.
  - i_rst during REQ aborts the access immediately: req drops next cycle, with no rdone/error pulse.
  - The counter clears on every accept.

Decomposition:
- Shared header lsu.mac.vh holds:
  - state encodings LSU_ST_IDLE/REQ/DONE
  - MEM_SIZE_B/H/W = 1/2/4
- Sub-module lsu_align is combinational lane steering:
  - size, addr[1:0], wdata in; be and replicated wdata out
  - rdata, size, unsigned, addr[1:0] in; extended load data out
- lsu_rv32i instantiates lsu_align twice, or once with both functions.

Test Plan:
- LB, addr 0x1003, rdata 0x80FF_0000, ack in first REQ cycle -> be=4'b1000, o_rdone at accept+2, o_rdata=0xFFFF_FF80, o_busy high 2 cycles.
- LHU, addr 0x2002, rdata 0xBEEF_1234, ack after 3 wait cycles -> be=4'b1100, o_rdata=0x0000_BEEF, rdone at accept+5.
- SH, addr 0x10, wdata 0x1234_ABCD -> o_mem_we=1, be=4'b0011, o_mem_wdata=0xABCD_ABCD, no rdone, busy clears in DONE.
- LW, addr 0x6 -> no o_mem_req, o_misalign pulse at accept+1, o_rdone=0; i_mem_size=3 behaves the same.
- TIMEOUT=4, load, never ack -> req high 4 cycles, then o_timeout pulse, IDLE. Repeat with ack on the 4th cycle -> rdone, no timeout.
- i_rst asserted mid-REQ, then late ack -> all outputs 0 after reset, ack ignored. Next LW at 0x0 completes normally.

Source files
------------

// File: rtl/lsu_rv32i_pkg.sv
// Shared definitions for the RV32I load/store unit.
//   lsu_state_t    : IDLE / REQ / DONE controller states
//   MEM_SIZE_B/H/W : access sizes in bytes as encoded on i_mem_size
//   lsu_misaligned : legality check for a size / low address pair
package lsu_rv32i_pkg;

    typedef enum logic [1:0] {
        LSU_ST_IDLE = 2'd0,
        LSU_ST_REQ  = 2'd1,
        LSU_ST_DONE = 2'd2
    } lsu_state_t;

    localparam logic [3:0] MEM_SIZE_B = 4'd1;
    localparam logic [3:0] MEM_SIZE_H = 4'd2;
    localparam logic [3:0] MEM_SIZE_W = 4'd4;

    // Unknown sizes are treated as misaligned so they never reach memory.
    function automatic logic lsu_misaligned(input logic [3:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            MEM_SIZE_B: bad = 1'b0;
            MEM_SIZE_H: bad = addr_lo[0];
            MEM_SIZE_W: bad = (addr_lo != 2'b00);
            default:    bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_rv32i_align.sv
// Combinational byte-lane steering for the load/store unit.
//   Store side: st_size, st_addr_lo, st_wdata -> st_be, st_data (lane-replicated)
//   Load side : ld_rdata, ld_size, ld_unsigned, ld_addr_lo -> ld_data (extended)
module lsu_rv32i_align
    import lsu_rv32i_pkg::*;
(
    input  logic [3:0]  st_size,
    input  logic [1:0]  st_addr_lo,
    input  logic [31:0] st_wdata,
    output logic [3:0]  st_be,
    output logic [31:0] st_data,
    input  logic [3:0]  ld_size,
    input  logic        ld_unsigned,
    input  logic [1:0]  ld_addr_lo,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data
);

    logic [31:0] shifted;

    always_comb begin
        st_be   = 4'b0000;
        st_data = st_wdata;
        case (st_size)
            MEM_SIZE_B: begin
                st_be   = 4'b0001 << st_addr_lo;
                st_data = {4{st_wdata[7:0]}};
            end
            MEM_SIZE_H: begin
                st_be   = 4'b0011 << st_addr_lo;
                st_data = {2{st_wdata[15:0]}};
            end
            MEM_SIZE_W: st_be = 4'b1111;
            default:    st_be = 4'b0000;
        endcase
    end

    // Move the addressed lane down to bit 0, then sign- or zero-extend.
    assign shifted = ld_rdata >> {ld_addr_lo, 3'b000};

    always_comb begin
        case (ld_size)
            MEM_SIZE_B: ld_data = {{24{~ld_unsigned & shifted[7]}}, shifted[7:0]};
            MEM_SIZE_H: ld_data = {{16{~ld_unsigned & shifted[15]}}, shifted[15:0]};
            default:    ld_data = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_rv32i.sv
// RV32I load/store unit.
// Accepts one memory op from execute, drives a word-addressed req/ack data port
// with byte enables, stalls the core until completion and returns extended load
// data. Misaligned ops are rejected without a memory request; a request that is
// not acknowledged within TIMEOUT cycles is aborted (TIMEOUT = 0 waits forever).
//   Core side  : i_valid, i_is_store, i_mem_size, i_unsigned, i_addr, i_wdata ->
//                o_busy (comb), o_rdone, o_rdata, o_misalign, o_timeout
//   Memory side: o_mem_req, o_mem_we, o_mem_addr, o_mem_be, o_mem_wdata <-
//                i_mem_ack, i_mem_rdata
module lsu_rv32i
    import lsu_rv32i_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    input  logic        i_is_store,
    input  logic [3:0]  i_mem_size,
    input  logic        i_unsigned,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_busy,
    output logic        o_rdone,
    output logic [31:0] o_rdata,
    output logic        o_misalign,
    output logic        o_timeout,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [3:0]  o_mem_be,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata
);

    lsu_state_t  state_reg;
    logic [31:0] cnt_reg;
    logic        is_store_reg;
    logic [3:0]  size_reg;
    logic        unsigned_reg;
    logic [1:0]  addr_lo_reg;

    logic [3:0]  st_be;
    logic [31:0] st_data;
    logic [31:0] ld_data;

    // Store steering works on the live request; load extraction on the captured one.
    lsu_rv32i_align u_align (
        .st_size     (i_mem_size),
        .st_addr_lo  (i_addr[1:0]),
        .st_wdata    (i_wdata),
        .st_be       (st_be),
        .st_data     (st_data),
        .ld_size     (size_reg),
        .ld_unsigned (unsigned_reg),
        .ld_addr_lo  (addr_lo_reg),
        .ld_rdata    (i_mem_rdata),
        .ld_data     (ld_data)
    );

    // Busy is low in DONE so the core advances exactly once per access.
    assign o_busy = ((state_reg == LSU_ST_IDLE) && i_valid) || (state_reg == LSU_ST_REQ);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg    <= LSU_ST_IDLE;
            cnt_reg      <= '0;
            is_store_reg <= 1'b0;
            size_reg     <= '0;
            unsigned_reg <= 1'b0;
            addr_lo_reg  <= '0;
            o_rdone      <= 1'b0;
            o_rdata      <= '0;
            o_misalign   <= 1'b0;
            o_timeout    <= 1'b0;
            o_mem_req    <= 1'b0;
            o_mem_we     <= 1'b0;
            o_mem_addr   <= '0;
            o_mem_be     <= '0;
            o_mem_wdata  <= '0;
        end else begin
            o_rdone    <= 1'b0;
            o_misalign <= 1'b0;
            o_timeout  <= 1'b0;
            case (state_reg)
                LSU_ST_IDLE: begin
                    if (i_valid) begin
                        cnt_reg      <= '0;
                        is_store_reg <= i_is_store;
                        size_reg     <= i_mem_size;
                        unsigned_reg <= i_unsigned;
                        addr_lo_reg  <= i_addr[1:0];
                        o_rdata      <= '0;
                        if (lsu_misaligned(i_mem_size, i_addr[1:0])) begin
                            state_reg  <= LSU_ST_DONE;
                            o_misalign <= 1'b1;
                        end else begin
                            state_reg   <= LSU_ST_REQ;
                            o_mem_req   <= 1'b1;
                            o_mem_we    <= i_is_store;
                            o_mem_addr  <= {i_addr[31:2], 2'b00};
                            o_mem_be    <= st_be;
                            o_mem_wdata <= i_is_store ? st_data : 32'd0;
                        end
                    end
                end
                LSU_ST_REQ: begin
                    // Ack takes priority over the timeout limit on the same cycle.
                    if (i_mem_ack || ((TIMEOUT != 0) && (cnt_reg == TIMEOUT - 1))) begin
                        state_reg   <= LSU_ST_DONE;
                        o_mem_req   <= 1'b0;
                        o_mem_we    <= 1'b0;
                        o_mem_addr  <= '0;
                        o_mem_be    <= '0;
                        o_mem_wdata <= '0;
                        if (!i_mem_ack) begin
                            o_timeout <= 1'b1;
                        end else if (!is_store_reg) begin
                            o_rdone <= 1'b1;
                            o_rdata <= ld_data;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 32'd1;
                    end
                end
                LSU_ST_DONE: begin
                    state_reg <= LSU_ST_IDLE;
                    o_rdata   <= '0;
                end
                default: state_reg <= LSU_ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_rv32i.sv
module tb_lsu_rv32i;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic        is_store;
    logic [3:0]  mem_size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        rdone;
    logic [31:0] rdata;
    logic        misalign;
    logic        timeout;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    lsu_rv32i #(.TIMEOUT(TO)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_valid     (valid),
        .i_is_store  (is_store),
        .i_mem_size  (mem_size),
        .i_unsigned  (uns),
        .i_addr      (addr),
        .i_wdata     (wdata),
        .o_busy      (busy),
        .o_rdone     (rdone),
        .o_rdata     (rdata),
        .o_misalign  (misalign),
        .o_timeout   (timeout),
        .o_mem_req   (mem_req),
        .o_mem_we    (mem_we),
        .o_mem_addr  (mem_addr),
        .o_mem_be    (mem_be),
        .o_mem_wdata (mem_wdata),
        .i_mem_ack   (mem_ack),
        .i_mem_rdata (mem_rdata)
    );

    // ---------------- reference model (byte-level arithmetic) ----------------
    function automatic bit m_misaligned(input int sz, input logic [31:0] a);
        if (!(sz == 1 || sz == 2 || sz == 4)) return 1'b1;
        return (int'(a[1:0]) % sz) != 0;
    endfunction

    function automatic logic [3:0] m_be(input int sz, input logic [31:0] a);
        int v;
        v = ((1 << sz) - 1) << int'(a[1:0]);
        return v[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(input bit st, input int sz, input logic [31:0] wd);
        logic [31:0] r;
        for (int k = 0; k < 4; k++) r[k*8 +: 8] = wd[(k % sz)*8 +: 8];
        return st ? r : 32'd0;
    endfunction

    function automatic logic [31:0] m_load(input int sz, input bit u, input logic [31:0] a,
                                           input logic [31:0] rd);
        logic [31:0] v;
        logic [31:0] mask;
        v = rd >> (int'(a[1:0]) * 8);
        if (sz == 4) return v;
        mask = (32'd1 << (sz * 8)) - 32'd1;
        v = v & mask;
        if (!u && v[sz*8-1]) v = v | ~mask;
        return v;
    endfunction

    // One full access: accept, REQ phase with ack after wait_n wait cycles
    // (wait_n >= TO means never ack), DONE cycle and the following idle cycle.
    task automatic do_access(input string name, input bit st, input logic [3:0] sz,
                             input bit u, input logic [31:0] a, input logic [31:0] wd,
                             input logic [31:0] rd, input int wait_n, input bit poke_done);
        bit          bad;
        bit          ok;
        int          n;
        int          busy_cnt;
        int          req_cnt;
        int          exp_req;
        int          exp_busy;
        logic [3:0]  e_be;
        logic [31:0] e_wd;
        logic [31:0] e_rd;
        bad  = m_misaligned(int'(sz), a);
        ok   = !bad && (wait_n < TO);
        e_be = bad ? 4'b0000 : m_be(int'(sz), a);
        e_wd = bad ? 32'd0 : m_wdata(st, int'(sz), wd);
        e_rd = (ok && !st) ? m_load(int'(sz), u, a, rd) : 32'd0;
        exp_req  = bad ? 0 : ((wait_n + 1 < TO) ? wait_n + 1 : TO);
        exp_busy = exp_req + 1;
        busy_cnt = 0;
        req_cnt  = 0;

        @(posedge clk); #1;
        valid = 1'b1; is_store = st; mem_size = sz; uns = u; addr = a; wdata = wd;
        #1;
        if (busy) busy_cnt++;
        checks++;
        if (mem_req !== 1'b0) begin
            errors++; $display("FAIL %s req_before_accept got=%b exp=0", name, mem_req);
        end
        @(posedge clk); #1;
        valid = 1'b0; wdata = $urandom; addr = $urandom;

        if (!bad) begin
            n = 0;
            while (n < exp_req && n < 40) begin
                if (busy) busy_cnt++;
                if (mem_req) req_cnt++;
                checks++;
                if ({mem_req, mem_we, mem_addr, mem_be, mem_wdata} !==
                    {1'b1, st, {a[31:2], 2'b00}, e_be, e_wd}) begin
                    errors++;
                    $display("FAIL %s mem_port got=req%b we%b a%h be%b wd%h exp=req1 we%b a%h be%b wd%h",
                             name, mem_req, mem_we, mem_addr, mem_be, mem_wdata,
                             st, {a[31:2], 2'b00}, e_be, e_wd);
                end
                mem_ack   = (n == wait_n);
                mem_rdata = (n == wait_n) ? rd : $urandom;
                @(posedge clk); #1;
                mem_ack = 1'b0;
                n++;
            end
        end

        // DONE cycle
        if (busy) busy_cnt++;
        checks++;
        if ({rdone, rdata, misalign, timeout, mem_req} !==
            {ok && !st, e_rd, bad, !bad && !ok, 1'b0}) begin
            errors++;
            $display("FAIL %s done got=rdone%b rdata%h mis%b to%b req%b exp=rdone%b rdata%h mis%b to%b req0",
                     name, rdone, rdata, misalign, timeout, mem_req,
                     ok && !st, e_rd, bad, !bad && !ok);
        end
        checks++;
        if (req_cnt !== exp_req || busy_cnt !== exp_busy) begin
            errors++;
            $display("FAIL %s cycles got=req%0d busy%0d exp=req%0d busy%0d",
                     name, req_cnt, busy_cnt, exp_req, exp_busy);
        end
        if (poke_done) begin
            // valid and ack during DONE must both be ignored
            valid = 1'b1; mem_ack = 1'b1; mem_rdata = $urandom;
            #1;
            checks++;
            if (busy !== 1'b0) begin
                errors++; $display("FAIL %s busy_in_done got=%b exp=0", name, busy);
            end
            @(negedge clk);
            valid = 1'b0; mem_ack = 1'b0;
        end
        @(posedge clk); #1;
        checks++;
        if ({rdone, misalign, timeout, mem_req, busy, rdata} !== 37'd0) begin
            errors++;
            $display("FAIL %s idle_after got=rdone%b mis%b to%b req%b busy%b rdata%h exp=all0",
                     name, rdone, misalign, timeout, mem_req, busy, rdata);
        end
        $display("%s: st=%0d size=%0d uns=%0d addr=%h wait=%0d -> be=%b wd=%h rd=%h mis=%0d ok=%0d",
                 name, st, sz, u, a, wait_n, e_be, e_wd, e_rd, bad, ok);
    endtask

    task automatic test_reset();
        rst = 1'b1; valid = 1'b0; is_store = 1'b0; mem_size = 4'd0; uns = 1'b0;
        addr = '0; wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if ({busy, rdone, rdata, misalign, timeout, mem_req, mem_we, mem_addr, mem_be, mem_wdata} !== 108'd0) begin
            errors++;
            $display("FAIL reset outputs got=busy%b rdone%b rdata%h mis%b to%b req%b we%b a%h be%b wd%h exp=all0",
                     busy, rdone, rdata, misalign, timeout, mem_req, mem_we, mem_addr, mem_be, mem_wdata);
        end
        $display("reset: outputs checked");
    endtask

    task automatic test_load_signed();
        do_access("lb_signed", 1'b0, 4'd1, 1'b0, 32'h0000_1003, 32'h0, 32'h80FF_0000, 0, 1'b0);
    endtask

    task automatic test_load_wait();
        do_access("lhu_wait3", 1'b0, 4'd2, 1'b1, 32'h0000_2002, 32'h0, 32'hBEEF_1234, 3, 1'b0);
    endtask

    task automatic test_store();
        do_access("sh_store", 1'b1, 4'd2, 1'b0, 32'h0000_0010, 32'h1234_ABCD, 32'hDEAD_BEEF, 0, 1'b1);
    endtask

    task automatic test_misalign();
        do_access("lw_misalign", 1'b0, 4'd4, 1'b0, 32'h0000_0006, 32'h0, 32'h1111_2222, 0, 1'b0);
        do_access("size3_illegal", 1'b0, 4'd3, 1'b0, 32'h0000_0000, 32'h0, 32'h1111_2222, 0, 1'b0);
        do_access("sh_odd", 1'b1, 4'd2, 1'b0, 32'h0000_0101, 32'h55AA_55AA, 32'h0, 0, 1'b0);
    endtask

    task automatic test_timeout();
        do_access("load_timeout", 1'b0, 4'd4, 1'b0, 32'h0000_0100, 32'h0, 32'hCAFE_F00D, TO, 1'b0);
        do_access("ack_at_limit", 1'b0, 4'd4, 1'b0, 32'h0000_0100, 32'h0, 32'hCAFE_F00D, TO - 1, 1'b0);
    endtask

    task automatic test_rst_mid_req();
        @(posedge clk); #1;
        valid = 1'b1; is_store = 1'b0; mem_size = 4'd4; uns = 1'b0; addr = 32'h40;
        @(posedge clk); #1;
        valid = 1'b0;
        checks++;
        if (mem_req !== 1'b1) begin
            errors++; $display("FAIL rst_mid_req req_before got=%b exp=1", mem_req);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if ({busy, rdone, rdata, misalign, timeout, mem_req, mem_we, mem_addr, mem_be, mem_wdata} !== 108'd0) begin
            errors++;
            $display("FAIL rst_mid_req after_rst got=busy%b rdone%b req%b be%b exp=all0",
                     busy, rdone, mem_req, mem_be);
        end
        mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        checks++;
        if ({rdone, rdata, timeout, misalign, mem_req, busy} !== 37'd0) begin
            errors++;
            $display("FAIL rst_mid_req late_ack got=rdone%b rdata%h req%b busy%b exp=all0",
                     rdone, rdata, mem_req, busy);
        end
        $display("rst_mid_req: aborted access, late ack ignored");
        do_access("lw_after_rst", 1'b0, 4'd4, 1'b0, 32'h0000_0000, 32'h0, 32'h8765_4321, 1, 1'b0);
    endtask

    task automatic test_random();
        int sizes[9] = '{1, 2, 4, 1, 2, 4, 3, 0, 8};
        int sz;
        logic [31:0] a;
        for (int i = 0; i < 60; i++) begin
            sz = sizes[$urandom_range(0, 8)];
            a  = $urandom;
            if ((sz == 1 || sz == 2 || sz == 4) && $urandom_range(0, 3) != 0)
                a = a & ~(32'(sz) - 32'd1);
            do_access($sformatf("rand%0d", i), 1'($urandom_range(0, 1)), 4'(sz),
                      1'($urandom_range(0, 1)), a, $urandom, $urandom,
                      $urandom_range(0, TO), 1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset();
        test_load_signed();
        test_load_wait();
        test_store();
        test_misalign();
        test_timeout();
        test_rst_mid_req();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
